// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the writeback sources, decode, the register file write port
// and rf_wb_arbiter.
interface rf_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_ready;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_busy1;
    logic        q_busy2;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Arbiter side.
    modport slave (
        input  a_valid, a_waddr, a_wdata,
        output a_ready,
        input  b_valid, b_waddr, b_wdata,
        output b_ready,
        input  alloc_valid, alloc_addr, q_addr1, q_addr2,
        output q_busy1, q_busy2,
        output rf_wen, rf_waddr, rf_wdata
    );

    // Source/decode side.
    modport master (
        output a_valid, a_waddr, a_wdata,
        input  a_ready,
        output b_valid, b_waddr, b_wdata,
        input  b_ready,
        output alloc_valid, alloc_addr, q_addr1, q_addr2,
        input  q_busy1, q_busy2,
        input  rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (pipeline port A vs long-latency port B) with a
// pending-write scoreboard for decode RAW hazard detection.
module rf_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input logic           clk,
    input logic           reset,
    rf_wb_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] MaxWaitCnt = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             starve;
    logic             a_acc, b_acc;
    logic             wen_d;
    logic [4:0]       waddr_d;
    logic [31:0]      wdata_d;
    logic [31:0]      pending_q, pending_d;
    logic             rf_wen_q;
    logic [4:0]       rf_waddr_q;
    logic [31:0]      rf_wdata_q;

    // A wins by default; a starved B takes the port. Ready never looks at own valid.
    assign starve      = (wait_cnt_q == MaxWaitCnt);
    assign bus.a_ready = !(bus.b_valid && starve);
    assign bus.b_ready = !bus.a_valid || starve;
    assign a_acc       = bus.a_valid && bus.a_ready;
    assign b_acc       = bus.b_valid && bus.b_ready;

    // Count cycles B has been waiting, saturating at the starvation threshold.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.b_valid || b_acc) begin
            wait_cnt_d = '0;
        end else if (!starve) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Select the accepted request; r0 completes the handshake but never writes.
    always_comb begin
        if (b_acc) begin
            waddr_d = bus.b_waddr;
            wdata_d = bus.b_wdata;
        end else begin
            waddr_d = bus.a_waddr;
            wdata_d = bus.a_wdata;
        end
        wen_d = (a_acc || b_acc) && (waddr_d != 5'd0);
    end

    // Scoreboard update: clear on the register-file write edge, set on alloc (set wins).
    always_comb begin
        pending_d = pending_q;
        if (rf_wen_q) begin
            pending_d[rf_waddr_q] = 1'b0;
        end
        if (bus.alloc_valid) begin
            pending_d[bus.alloc_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            pending_q  <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            pending_q  <= pending_d;
            rf_wen_q   <= wen_d;
            rf_waddr_q <= waddr_d;
            rf_wdata_q <= wdata_d;
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.q_busy1  = pending_q[bus.q_addr1];
    assign bus.q_busy2  = pending_q[bus.q_addr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized + directed bench for rf_wb_arbiter with a queue-based write scoreboard.
module tb_rf_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic clk;
    logic reset;
    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t expq[$];

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 0;

    // Reference model state.
    int lost = 0;
    bit pend [32];
    bit prev_wen = 0;
    int prev_addr = 0;

    bit last_ar, last_br, last_busy1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: each cycle, rf_wen must be high exactly when a write is due.
    always @(negedge clk) begin
        if (mon_en) begin
            bit due_now;
            due_now = (expq.size() > 0) && (expq[0].due == cyc);
            chk("rf_wen", bus.rf_wen, due_now);
            if (due_now) begin
                if (bus.rf_wen === 1'b1) begin
                    chk("rf_waddr", bus.rf_waddr, expq[0].addr);
                    chk("rf_wdata", bus.rf_wdata, expq[0].data);
                end
                void'(expq.pop_front());
            end
        end
    end

    // One clock cycle of stimulus, starting just after a rising edge.
    task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                        input bit alv, input logic [4:0] ala,
                        input logic [4:0] q1, input logic [4:0] q2, input bit rst);
        bit b_win, a_win, m_starve;
        #1;
        reset = rst;
        bus.a_valid = av; bus.a_waddr = aa; bus.a_wdata = ad;
        bus.b_valid = bv; bus.b_waddr = ba; bus.b_wdata = bd;
        bus.alloc_valid = alv; bus.alloc_addr = ala;
        bus.q_addr1 = q1; bus.q_addr2 = q2;
        #1;
        m_starve = (lost >= MAX_WAIT);
        b_win = bv && (!av || m_starve);
        a_win = av && !b_win;
        chk("a_ready", bus.a_ready, !(bv && m_starve));
        chk("b_ready", bus.b_ready, !av || m_starve);
        chk("q_busy1", bus.q_busy1, pend[q1]);
        chk("q_busy2", bus.q_busy2, pend[q2]);
        last_ar = bus.a_ready; last_br = bus.b_ready; last_busy1 = bus.q_busy1;
        if (rst) begin
            lost = 0;
            foreach (pend[i]) pend[i] = 0;
            prev_wen = 0;
        end else begin
            if (b_win && ba != 0) expq.push_back('{cyc + 1, ba, bd});
            if (a_win && aa != 0) expq.push_back('{cyc + 1, aa, ad});
            lost = (bv && !b_win) ? ((lost + 1 > MAX_WAIT) ? MAX_WAIT : lost + 1) : 0;
            if (prev_wen) pend[prev_addr] = 0;
            if (alv) pend[ala] = 1;
            pend[0] = 0;
            prev_wen = (b_win && ba != 0) || (a_win && aa != 0);
            prev_addr = b_win ? int'(ba) : int'(aa);
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic [4:0] q1);
        step(0, 0, 0, 0, 0, 0, 0, 0, q1, 0, 0);
    endtask

    initial begin
        bit [5:0] bpat;
        reset = 1'b1;
        bus.a_valid = 0; bus.a_waddr = 0; bus.a_wdata = 0;
        bus.b_valid = 0; bus.b_waddr = 0; bus.b_wdata = 0;
        bus.alloc_valid = 0; bus.alloc_addr = 0;
        bus.q_addr1 = 0; bus.q_addr2 = 0;
        foreach (pend[i]) pend[i] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1;

        // Reset state: idle readies high, no write, nothing busy.
        chk("reset_a_ready", bus.a_ready, 1'b1);
        chk("reset_b_ready", bus.b_ready, 1'b1);
        chk("reset_rf_wen", bus.rf_wen, 1'b0);
        for (int i = 0; i < 32; i++) begin
            bus.q_addr1 = 5'(i); bus.q_addr2 = 5'(31 - i);
            #1;
            chk("reset_busy1", bus.q_busy1, 1'b0);
            chk("reset_busy2", bus.q_busy2, 1'b0);
        end
        @(posedge clk);

        // A and B together: A wins, B goes once A drops.
        step(1, 5, 32'h1234, 1, 6, 32'hBEEF, 0, 0, 0, 0, 0);
        chk("collide_b_ready", last_br, 1'b0);
        step(0, 0, 0, 1, 6, 32'hBEEF, 0, 0, 0, 0, 0);
        chk("b_after_a_ready", last_br, 1'b1);
        idle(0);

        // Starvation: B forced through on the fifth contested cycle.
        for (int k = 0; k < 6; k++) begin
            step(1, 5'(10 + k), 32'hA000 + k, 1, 20, 32'hB0B0, 0, 0, 0, 0, 0);
            bpat[k] = last_br;
        end
        chk("starve_pattern", bpat, 6'b010000);
        idle(0);

        // Alloc r7, write r7 at cycle 3: busy until cycle 5.
        step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
        idle(7);
        chk("alloc_busy", last_busy1, 1'b1);
        idle(7);
        step(1, 7, 32'h7777, 0, 0, 0, 0, 0, 7, 0, 0);
        idle(7);
        chk("busy_during_write", last_busy1, 1'b1);
        idle(7);
        chk("busy_cleared", last_busy1, 1'b0);

        // Alloc r9 on the same edge as the r9 write: stays busy.
        step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        step(1, 9, 32'h9999, 0, 0, 0, 0, 0, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        idle(9);
        chk("set_wins", last_busy1, 1'b1);
        // r0 alloc and write: no rf_wen, never busy.
        step(1, 0, 32'hDEAD, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(0);
        chk("r0_not_busy", last_busy1, 1'b0);
        idle(0);

        // Reset after an A accept with B partly starved.
        step(1, 2, 32'h2222, 1, 4, 32'h4444, 0, 0, 0, 0, 0);
        step(1, 3, 32'h3333, 1, 4, 32'h4444, 1, 4, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 1);
        idle(4);
        chk("reset_clears_busy", last_busy1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1, 5'(1 + k), 32'hC0 + k, 1, 8, 32'h8888, 0, 0, 0, 0, 0);
            bpat[k] = last_br;
        end
        chk("starve_after_reset", bpat[4:0], 5'b10000);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 9) < 6, 5'($urandom), $urandom,
                 $urandom_range(0, 9) < 5, 5'($urandom), $urandom,
                 $urandom_range(0, 9) < 4, 5'($urandom),
                 5'($urandom), 5'($urandom), $urandom_range(0, 99) == 0);
        end
        repeat (3) idle(0);
        chk("queue_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
